// File: rtl/dmux_pkg.sv
// Shared select encoding and channel count for the registered 1-to-2 demultiplexer.
package dmux_pkg;

    localparam int NUM_CH = 2;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    typedef logic [NUM_CH-1:0] valid_t;

    // One-hot channel flag for a given select value.
    function automatic valid_t sel_to_valid(input logic sel);
        return (sel == CH1) ? valid_t'(2'b10) : valid_t'(2'b01);
    endfunction

endpackage

// File: rtl/dmux_out_reg.sv
// WIDTH-bit output register with synchronous active-high reset and load enable.
module dmux_out_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dmux_1by2.sv
// Registered 1-to-2 demultiplexer: routes i to the channel picked by s, zeroes the other.
module dmux_1by2
    import dmux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     i,
    input  logic                 s,
    input  logic                 en,
    output logic [2*WIDTH-1:0]   y,
    output logic [NUM_CH-1:0]    y_valid
);

    logic [WIDTH-1:0] ch_d [NUM_CH];
    logic [WIDTH-1:0] ch_q [NUM_CH];

    // NOTE: every always_comb output gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        ch_d[0] = '0;
        ch_d[1] = '0;
        if (s == CH1) begin
            ch_d[1] = i;
        end else begin
            ch_d[0] = i;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dmux_out_reg #(
            .WIDTH(WIDTH)
        ) u_out_reg (
            .clk(clk),
            .rst(rst),
            .en (en),
            .d  (ch_d[g]),
            .q  (ch_q[g])
        );

        assign y[g*WIDTH +: WIDTH] = ch_q[g];
    end

    // Valid flags share the channel registers' reset/enable so they stay in lockstep.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_valid <= '0;
        end else if (en) begin
            y_valid <= sel_to_valid(s);
        end
    end

endmodule

// File: tb/tb_dmux_1by2.sv
// Self-checking bench for dmux_1by2 at WIDTH=1 and WIDTH=8 against an arithmetic model.
module tb_dmux_1by2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        s   = 1'b0;
    logic [0:0]  i1  = '0;
    logic [7:0]  i8  = '0;
    logic [1:0]  y1;
    logic [1:0]  v1;
    logic [15:0] y8;
    logic [1:0]  v8;

    int checks = 0;
    int errors = 0;

    // Reference model state: expected outputs after the most recent edge.
    logic [1:0]  m_y1 = '0;
    logic [15:0] m_y8 = '0;
    logic [1:0]  m_v  = '0;

    always #5 clk = ~clk;

    dmux_1by2 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .i(i1), .s(s), .en(en), .y(y1), .y_valid(v1)
    );

    dmux_1by2 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .i(i8), .s(s), .en(en), .y(y8), .y_valid(v8)
    );

    // Drive one cycle of inputs, advance the model across the edge, sample at negedge.
    task automatic cycle(input logic r, input logic e, input logic sel,
                         input logic d1, input logic [7:0] d8);
        rst = r;
        en  = e;
        s   = sel;
        i1  = d1;
        i8  = d8;
        @(posedge clk);
        if (r) begin
            m_y1 = '0;
            m_y8 = '0;
            m_v  = '0;
        end else if (e) begin
            m_y1 = 2'(int'(d1) << int'(sel));
            m_y8 = 16'(int'(d8) << (8 * int'(sel)));
            m_v  = 2'(1 << int'(sel));
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
        checks++;
        if ({y1, v1, y8, v8} !== 20'h0) begin
            errors++;
            $display("FAIL reset: y1=%b v1=%b y8=%h v8=%b, required all zero", y1, v1, y8, v8);
        end
    endtask

    task automatic test_route_ch0();
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5);
        checks++;
        if ({y1, v1} !== 4'b01_01) begin
            errors++;
            $display("FAIL route_ch0_w1: y1=%b v1=%b, required y1=01 v1=01", y1, v1);
        end
        checks++;
        if ({y8, v8} !== {16'h00A5, 2'b01}) begin
            errors++;
            $display("FAIL route_ch0_w8: y8=%h v8=%b, required y8=00a5 v8=01", y8, v8);
        end
    endtask

    task automatic test_route_ch1();
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h3C);
        checks++;
        if ({y1, v1, y8, v8} !== {2'b10, 2'b10, 16'h3C00, 2'b10}) begin
            errors++;
            $display("FAIL route_ch1: y1=%b v1=%b y8=%h v8=%b, required 10 10 3c00 10", y1, v1, y8, v8);
        end
        // Selected zero data: y all zero but valid still flags channel 1.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        checks++;
        if ({y1, v1, y8, v8} !== {2'b00, 2'b10, 16'h0000, 2'b10}) begin
            errors++;
            $display("FAIL zero_data: y1=%b v1=%b y8=%h v8=%b, required 00 10 0000 10", y1, v1, y8, v8);
        end
    endtask

    task automatic test_hold();
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h3C);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
            checks++;
            if ({y1, v1, y8, v8} !== {2'b10, 2'b10, 16'h3C00, 2'b10}) begin
                errors++;
                $display("FAIL hold[%0d]: y1=%b v1=%b y8=%h v8=%b, required 10 10 3c00 10",
                         k, y1, v1, y8, v8);
            end
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h5A);
        checks++;
        if ({y1, v1, y8, v8} !== {2'b01, 2'b01, 16'h005A, 2'b01}) begin
            errors++;
            $display("FAIL hold_release: y1=%b v1=%b y8=%h v8=%b, required 01 01 005a 01", y1, v1, y8, v8);
        end
    endtask

    task automatic test_reset_midstream();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 1'(k), 1'b1, 8'(8'h11 * (k + 1)));
            checks++;
            if ({y1, v1, y8, v8} !== {m_y1, m_v, m_y8, m_v}) begin
                errors++;
                $display("FAIL toggle[%0d]: got %b %b %h %b, required %b %b %h %b",
                         k, y1, v1, y8, v8, m_y1, m_v, m_y8, m_v);
            end
        end
        // Reset wins over a disabled enable as well as an enabled one.
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'hEE);
        checks++;
        if ({y1, v1, y8, v8} !== 20'h0) begin
            errors++;
            $display("FAIL midstream_reset: y1=%b v1=%b y8=%h v8=%b, required all zero", y1, v1, y8, v8);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
        checks++;
        if ({y1, v1, y8, v8} !== 20'h0) begin
            errors++;
            $display("FAIL post_reset_idle: y1=%b v1=%b y8=%h v8=%b, required all zero", y1, v1, y8, v8);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h81);
        checks++;
        if ({y1, v1, y8, v8} !== {2'b10, 2'b10, 16'h8100, 2'b10}) begin
            errors++;
            $display("FAIL resume: y1=%b v1=%b y8=%h v8=%b, required 10 10 8100 10", y1, v1, y8, v8);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), 1'($urandom), 8'($urandom));
            checks++;
            if ({y1, v1, y8, v8} !== {m_y1, m_v, m_y8, m_v}) begin
                errors++;
                $display("FAIL random[%0d]: got %b %b %h %b, required %b %b %h %b",
                         k, y1, v1, y8, v8, m_y1, m_v, m_y8, m_v);
            end
            checks++;
            if ($countones(v8) > 1 || (y8[15:8] != 8'h00 && y8[7:0] != 8'h00)) begin
                errors++;
                $display("FAIL exclusive[%0d]: y8=%h v8=%b, required at most one active channel", k, y8, v8);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_route_ch0();
        test_route_ch1();
        test_hold();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
